// File: rtl/divisor_frecuencia_prog_if.sv
// Control/status bundle of the programmable clock divider: run enables,
// divisor write port, phase sync and the per-channel outputs.
interface divisor_frecuencia_prog_if #(
    parameter int CANALES = 4,
    parameter int ANCHO   = 26
);
    localparam int SEL_W = (CANALES > 1) ? $clog2(CANALES) : 1;

    logic [CANALES-1:0] en;
    logic               div_wr;
    logic [SEL_W-1:0]   div_sel;
    logic [ANCHO-1:0]   div_dato;
    logic               sync;
    logic [CANALES-1:0] clk_out;
    logic [CANALES-1:0] tick;
    logic [CANALES-1:0] activo;

    modport master (
        output en, div_wr, div_sel, div_dato, sync,
        input  clk_out, tick, activo
    );

    modport slave (
        input  en, div_wr, div_sel, div_dato, sync,
        output clk_out, tick, activo
    );
endinterface

// File: rtl/divisor_frecuencia_prog.sv
// Multi-channel programmable divider: each channel emits a 50 % square wave
// of period 2*div clk cycles plus a one-cycle tick on every rising edge.
//
// state   | meaning
// S_IDLE  | stopped, clk_out low, counter cleared
// S_RUN   | counting, toggling clk_out at every boundary
// S_DRAIN | enable dropped while high; finish the high phase, then stop
module divisor_frecuencia_prog #(
    parameter int CANALES   = 4,
    parameter int ANCHO     = 26,
    parameter int DIV_RESET = 250000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    divisor_frecuencia_prog_if.slave bus
);
    localparam int               SEL_W     = (CANALES > 1) ? $clog2(CANALES) : 1;
    localparam logic [ANCHO-1:0] C_DIV_RST = ANCHO'(DIV_RESET);
    localparam logic [ANCHO-1:0] C_UNO     = ANCHO'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } estado_t;

    logic [CANALES-1:0] w_clk_out;
    logic [CANALES-1:0] w_tick;
    logic [CANALES-1:0] w_activo;
    logic [ANCHO-1:0]   w_dato;

    // A zero divisor would never reach a boundary; treat it as the fastest rate.
    assign w_dato = (bus.div_dato == '0) ? C_UNO : bus.div_dato;

    for (genvar gi = 0; gi < CANALES; gi++) begin : g_canal
        estado_t          r_estado;
        estado_t          w_estado_sig;
        logic [ANCHO-1:0] r_div;
        logic [ANCHO-1:0] r_shadow;
        logic [ANCHO-1:0] r_cnt;
        logic             r_clk;
        logic             r_tick;
        logic             w_fin;
        logic             w_wr;
        logic             w_corre;
        logic             w_resinc;
        logic             w_para;

        assign w_fin = (r_cnt >= r_div - C_UNO);
        assign w_wr  = bus.div_wr && (bus.div_sel == SEL_W'(gi));

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_estado <= S_IDLE;
            end else begin
                r_estado <= w_estado_sig;
            end
        end

        always_comb begin
            w_estado_sig = r_estado;
            case (r_estado)
                S_IDLE: begin
                    if (bus.en[gi]) w_estado_sig = S_RUN;
                end
                S_RUN: begin
                    if (bus.sync) begin
                        w_estado_sig = S_RUN;
                    end else if (!bus.en[gi]) begin
                        if (!r_clk || w_fin) w_estado_sig = S_IDLE;
                        else                 w_estado_sig = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (bus.sync)        w_estado_sig = S_IDLE;
                    else if (bus.en[gi]) w_estado_sig = S_RUN;
                    else if (w_fin)      w_estado_sig = S_IDLE;
                end
                default: w_estado_sig = S_IDLE;
            endcase
        end

        always_comb begin
            w_corre  = (r_estado != S_IDLE);
            w_resinc = w_corre && bus.sync;
            w_para   = (r_estado == S_RUN) && !bus.en[gi] && !r_clk;
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_div    <= C_DIV_RST;
                r_shadow <= C_DIV_RST;
                r_cnt    <= '0;
                r_clk    <= 1'b0;
                r_tick   <= 1'b0;
            end else begin
                if (w_wr) r_shadow <= w_dato;
                r_tick <= 1'b0;
                if (w_resinc) begin
                    r_cnt <= '0;
                    r_clk <= 1'b0;
                    r_div <= r_shadow;
                end else if (w_para) begin
                    r_cnt <= '0;
                end else if (w_corre) begin
                    // Boundary reads the pre-write shadow, so a coincident write lands one boundary later.
                    if (w_fin) begin
                        r_cnt  <= '0;
                        r_clk  <= ~r_clk;
                        r_tick <= ~r_clk;
                        r_div  <= r_shadow;
                    end else begin
                        r_cnt <= r_cnt + C_UNO;
                    end
                end else begin
                    r_cnt <= '0;
                    r_clk <= 1'b0;
                    if (w_wr) r_div <= w_dato;
                end
            end
        end

        assign w_clk_out[gi] = r_clk;
        assign w_tick[gi]    = r_tick;
        assign w_activo[gi]  = w_corre;
    end

    assign bus.clk_out = w_clk_out;
    assign bus.tick    = w_tick;
    assign bus.activo  = w_activo;
endmodule

// File: tb/tb_divisor_frecuencia_prog.sv
// Directed bench for divisor_frecuencia_prog with two channels and a reset
// half-period of 3; expected waveforms are written out by hand per scenario.
module tb_divisor_frecuencia_prog;
    localparam int CANALES   = 2;
    localparam int ANCHO     = 26;
    localparam int DIV_RESET = 3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    divisor_frecuencia_prog_if #(.CANALES(CANALES), .ANCHO(ANCHO)) bus ();

    divisor_frecuencia_prog #(
        .CANALES  (CANALES),
        .ANCHO    (ANCHO),
        .DIV_RESET(DIV_RESET)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tic;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst          = 1'b1;
        bus.en       = '0;
        bus.div_wr   = 1'b0;
        bus.div_sel  = '0;
        bus.div_dato = '0;
        bus.sync     = 1'b0;
        tic;
        tic;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        logic [5:0] obs;
        do_reset;
        for (int k = 1; k <= 3; k++) begin
            tic;
            obs = {bus.activo, bus.tick, bus.clk_out};
            checks++;
            if (obs !== 6'b0) begin
                errors++;
                $display("FAIL reset k=%0d got %b want %b", k, obs, 6'b0);
            end
        end
    endtask

    task automatic test_basic;
        logic [5:0] obs;
        logic [5:0] exp;
        logic e_clk;
        logic e_tick;
        logic prev;
        do_reset;
        bus.en = 2'b01;
        prev = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tic;
            e_clk  = (((k - 1) / 3) % 2) == 1;
            e_tick = e_clk && !prev;
            prev   = e_clk;
            exp = {2'b01, 1'b0, e_tick, 1'b0, e_clk};
            obs = {bus.activo, bus.tick, bus.clk_out};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL basic k=%0d got %b want %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_write;
        logic [5:0] obs;
        logic [5:0] exp;
        logic e_clk;
        logic e_tick;
        logic prev;
        do_reset;
        bus.en = 2'b01;
        prev = 1'b0;
        for (int k = 1; k <= 44; k++) begin
            tic;
            if (k <= 18)      e_clk = (((k - 1) / 3) % 2) == 1;
            else if (k <= 23) e_clk = 1'b0;
            else if (k <= 28) e_clk = 1'b1;
            else if (k <= 33) e_clk = 1'b0;
            else if (k <= 38) e_clk = 1'b1;
            else if (k <= 40) e_clk = 1'b0;
            else if (k <= 42) e_clk = 1'b1;
            else              e_clk = 1'b0;
            e_tick = e_clk && !prev;
            prev   = e_clk;
            exp = {2'b01, 1'b0, e_tick, 1'b0, e_clk};
            obs = {bus.activo, bus.tick, bus.clk_out};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL write k=%0d got %b want %b", k, obs, exp);
            end
            // k==16: mid high phase; k==33: sampled on the boundary edge
            bus.div_wr   = (k == 16) || (k == 33);
            bus.div_sel  = '0;
            bus.div_dato = (k == 33) ? ANCHO'(2) : ANCHO'(5);
        end
        bus.div_wr = 1'b0;
    endtask

    task automatic test_div0;
        logic [5:0] obs;
        logic [5:0] exp;
        logic e_clk;
        do_reset;
        bus.div_wr   = 1'b1;
        bus.div_sel  = 1'b1;
        bus.div_dato = '0;
        tic;
        bus.div_wr = 1'b0;
        bus.en     = 2'b10;
        for (int j = 0; j < 8; j++) begin
            tic;
            e_clk = (j % 2) == 1;
            exp = {2'b10, e_clk, 1'b0, e_clk, 1'b0};
            obs = {bus.activo, bus.tick, bus.clk_out};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL div0 j=%0d got %b want %b", j, obs, exp);
            end
        end
    endtask

    task automatic test_drain;
        logic [1:22] en_tab;
        logic [2:0]  exp_tab [1:22];
        logic [5:0]  obs;
        logic [5:0]  exp;
        en_tab  = 22'b1111100011011110111111;
        exp_tab = '{3'b100, 3'b100, 3'b100, 3'b111, 3'b101, 3'b101, 3'b000, 3'b000,
                    3'b100, 3'b100, 3'b000, 3'b100, 3'b100, 3'b100, 3'b111, 3'b101,
                    3'b101, 3'b100, 3'b100, 3'b100, 3'b111, 3'b101};
        do_reset;
        for (int k = 1; k <= 22; k++) begin
            bus.en = {1'b0, en_tab[k]};
            tic;
            exp = {3'b000, exp_tab[k]};
            obs = {bus.activo[1], bus.tick[1], bus.clk_out[1],
                   bus.activo[0], bus.tick[0], bus.clk_out[0]};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL drain k=%0d got %b want %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_sync;
        logic [5:0] obs;
        do_reset;
        bus.en = 2'b01;
        tic;
        tic;
        bus.en = 2'b11;
        tic;
        tic;
        tic;
        obs = {bus.activo, bus.tick, bus.clk_out};
        checks++;
        if (obs !== 6'b11_00_01) begin
            errors++;
            $display("FAIL sync_pre got %b want %b", obs, 6'b11_00_01);
        end
        bus.sync = 1'b1;
        tic;
        bus.sync = 1'b0;
        obs = {bus.activo, bus.tick, bus.clk_out};
        checks++;
        if (obs !== 6'b11_00_00) begin
            errors++;
            $display("FAIL sync_hit got %b want %b", obs, 6'b11_00_00);
        end
        for (int j = 1; j <= 2; j++) begin
            tic;
            obs = {bus.activo, bus.tick, bus.clk_out};
            checks++;
            if (obs !== 6'b11_00_00) begin
                errors++;
                $display("FAIL sync_low j=%0d got %b want %b", j, obs, 6'b11_00_00);
            end
        end
        tic;
        obs = {bus.activo, bus.tick, bus.clk_out};
        checks++;
        if (obs !== 6'b11_11_11) begin
            errors++;
            $display("FAIL sync_rise got %b want %b", obs, 6'b11_11_11);
        end
        bus.en = 2'b10;
        tic;
        obs = {bus.activo, bus.tick, bus.clk_out};
        checks++;
        if (obs !== 6'b11_00_11) begin
            errors++;
            $display("FAIL sync_drain got %b want %b", obs, 6'b11_00_11);
        end
        bus.sync = 1'b1;
        tic;
        bus.sync = 1'b0;
        obs = {bus.activo, bus.tick, bus.clk_out};
        checks++;
        if (obs !== 6'b10_00_00) begin
            errors++;
            $display("FAIL sync_drain_idle got %b want %b", obs, 6'b10_00_00);
        end
    endtask

    task automatic test_async_reset;
        logic [5:0] obs;
        logic [5:0] exp;
        logic e_clk;
        do_reset;
        bus.div_wr   = 1'b1;
        bus.div_sel  = '0;
        bus.div_dato = ANCHO'(7);
        tic;
        bus.div_wr = 1'b0;
        bus.en     = 2'b01;
        for (int k = 1; k <= 8; k++) tic;
        obs = {bus.activo, bus.tick, bus.clk_out};
        checks++;
        if (obs !== 6'b01_01_01) begin
            errors++;
            $display("FAIL arst_pre got %b want %b", obs, 6'b01_01_01);
        end
        #3;
        rst = 1'b1;
        #1;
        obs = {bus.activo, bus.tick, bus.clk_out};
        checks++;
        if (obs !== 6'b0) begin
            errors++;
            $display("FAIL arst_now got %b want %b", obs, 6'b0);
        end
        tic;
        rst = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            tic;
            e_clk = (j >= 4);
            exp = {2'b01, 1'b0, (j == 4), 1'b0, e_clk};
            obs = {bus.activo, bus.tick, bus.clk_out};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL arst_after j=%0d got %b want %b", j, obs, exp);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_basic;
        test_write;
        test_div0;
        test_drain;
        test_sync;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/divisor_frecuencia_prog.md
Name: divisor_frecuencia_prog

Overview:
Parametrised multi-channel programmable clock divider and tick generator. Each channel takes a runtime-loadable half-period divisor and produces a 50 % duty square wave plus a one-cycle tick on each rising edge of that wave. The tick is the enable strobe for slow logic in the same clock domain. The block replaces fixed-constant dividers, such as the board LED blinker and the display refresh, and sits between the board clock input and the peripheral/display logic.

Parameters:
CANALES, 4, number of independent divider channels (1..16)
ANCHO, 26, width of divisor and counter registers in bits
DIV_RESET, 250000, half-period loaded into every channel at reset (must fit in ANCHO, must be >= 1)

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
en  in  CANALES  per-channel run enable, level
div_wr  in  1  single-cycle write strobe for a new divisor
div_sel  in  max(1,$clog2(CANALES))  channel addressed by div_wr
div_dato  in  ANCHO  new half-period value, in clk cycles
sync  in  1  single-cycle pulse; restarts all running channels phase-aligned
clk_out  out  CANALES  divided square waves, registered
tick  out  CANALES  one-cycle pulse when the matching clk_out rises, registered
activo  out  CANALES  channel running (counting or finishing its high phase)

Behaviour:
- Reset (async assert, sync release):
  - div[i] = shadow[i] = DIV_RESET
  - cnt[i] = 0
  - clk_out = 0, tick = 0, activo = 0
- Per-channel core when running:
  - cnt counts 0..div-1.
  - At cnt == div-1: cnt -> 0, clk_out toggles, div <- shadow (boundary load).
  - Output period = 2*div clk cycles.
  - div = 1 gives clk/2.
- tick[i] = 1 for exactly the cycle in which clk_out[i] is 1 for the first time after a 0->1 toggle. It is registered together with clk_out; no tick on the falling toggle.
- Divisor write:
  - div_wr = 1 writes div_dato into shadow[div_sel].
  - div_dato = 0 is stored as 1.
  - div_sel >= CANALES: write ignored.
  - A write landing in the same cycle as that channel's boundary takes effect at the following boundary; the boundary uses the old shadow.
  - A write to an idle channel (activo = 0) also loads div directly.
- Enable / state machine per channel, states IDLE, RUN, DRAIN:
  - IDLE: clk_out = 0, cnt = 0, activo = 0. en = 1 -> RUN next cycle. First rising edge of clk_out comes div cycles after entering RUN.
  - RUN: activo = 1. en = 0 while clk_out = 0 -> IDLE immediately (cnt cleared). en = 0 while clk_out = 1 -> DRAIN.
  - DRAIN: keeps counting until the falling toggle, then IDLE. en re-asserted during DRAIN -> back to RUN with no phase disturbance. No truncated high pulse is ever emitted.
- sync = 1:
  - Every channel in RUN or DRAIN: cnt -> 0, clk_out -> 0, div <- shadow, tick suppressed that cycle.
  - DRAIN channels go to IDLE; IDLE channels are unaffected.
  - All RUN channels with equal div then rise together div cycles later.
- Priority per cycle: rst > sync > en falling > boundary > div_wr direct-load.
- Counter never exceeds div-1. If div shrinks below the current cnt through a direct load, cnt restarts at 0.
- No combinational path from inputs to outputs.

Test Plan:
- CANALES=2, DIV_RESET=3, rst pulse, en=2'b01 -> ch0 clk_out period 6 cycles (3 high/3 low). First rise 3 cycles after RUN entry. tick one cycle per rise. ch1 stays 0, activo=2'b01.
- Write div_dato=5 to ch0 mid high phase -> current half-period stays 3; the next half-period and all later ones are 5 (period 10). Write coincident with a boundary -> applied one boundary later.
- div_dato=0 written to ch1, en[1]=1 -> ch1 behaves as div=1: clk_out toggles every cycle, tick every 2nd cycle.
- ch0 high with 1 cycle left, drop en -> DRAIN, falls after 1 cycle, then IDLE, activo=0. Drop en while low -> immediate IDLE. Re-assert en in DRAIN -> phase continues unbroken.
- ch0 div=3, ch1 div=3 out of phase, pulse sync -> both clk_out=0 next cycle, both rise together 3 cycles later, ticks coincide.
- Assert rst asynchronously mid-count with en held 1 -> outputs 0 immediately. After release, div=DIV_RESET and the first rise occurs DIV_RESET cycles after RUN entry.
